// File: rtl/title_scene_pkg.sv
// Shared types and constants for the title/game scene sequencer.
package title_scene_pkg;

    typedef enum logic [2:0] {
        FADE_IN_T  = 3'd0,
        TITLE_HOLD = 3'd1,
        FADE_OUT_T = 3'd2,
        FADE_IN_G  = 3'd3,
        GAME       = 3'd4,
        GAME_OVER  = 3'd5,
        FADE_OUT_G = 3'd6
    } scene_t;

    localparam logic [3:0] FADE_MAX  = 4'hF;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/title_scene_ctrl_frame_tick_gen.sv
// Frame tick from the falling edge of active-low vsync, plus a modulo-N
// tick counter whose wrap produces a one-cycle step strobe.
module frame_tick_gen #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    input  logic clr,
    output logic tick,
    output logic step
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic          vs_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = vs_q & ~vs;
    assign step = tick & (cnt_q == LAST);

    // clr wins over a simultaneous tick so a new scene always starts from zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr || step) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q  <= 1'b1;
            cnt_q <= '0;
        end else begin
            vs_q  <= vs;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/title_scene_ctrl.sv
// Scene sequencer: title/board selection, global fade level and new-game pulse.
// Optional TITLE_BLINK_EN: blink the "press start" prompt while on the title.
module title_scene_ctrl
    import title_scene_pkg::*;
#(
    parameter int         FADE_STEP_FRAMES = 4,
    parameter int         TITLE_MIN_FRAMES = 60,
    parameter int         OVER_FRAMES      = 180,
    parameter logic [7:0] START_KEY        = KEY_ENTER
`ifdef TITLE_BLINK_EN
    ,
    parameter int         BLINK_FRAMES     = 32
`endif
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vs,
    input  logic       key_valid,
    input  logic [7:0] keycode,
    input  logic       game_over,
    output logic [2:0] scene,
    output logic       title_sel,
    output logic [3:0] fade_level,
    output logic       game_start,
    output logic       game_active,
    output logic       prompt_vis
);

    localparam logic [15:0] MIN_CNT   = 16'(TITLE_MIN_FRAMES);
    localparam logic [15:0] OVER_LAST = 16'(OVER_FRAMES - 1);

    scene_t      state_q, state_d;
    logic [3:0]  fade_q, fade_d;
    logic [15:0] dwell_q, dwell_d;
    logic        title_sel_q, title_sel_d;
    logic        game_start_q, game_start_d;
    logic        game_active_q, game_active_d;
    logic        prompt_vis_q, prompt_vis_d;
    logic        tick, fade_step, state_chg, start_hit;

    assign state_chg = (state_d != state_q);
    assign start_hit = key_valid && (keycode == START_KEY);

    frame_tick_gen #(.N(FADE_STEP_FRAMES)) u_fade_tick (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .vs    (vs),
        .clr   (state_chg),
        .tick  (tick),
        .step  (fade_step)
    );

`ifdef TITLE_BLINK_EN
    logic blink_tick, blink_step;

    frame_tick_gen #(.N(BLINK_FRAMES)) u_blink_tick (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .vs    (vs),
        .clr   (state_chg),
        .tick  (blink_tick),
        .step  (blink_step)
    );
`endif

    always_comb begin
        state_d = state_q;
        fade_d  = fade_q;
        case (state_q)
            FADE_IN_T, FADE_IN_G: begin
                if (fade_step) begin
                    if (fade_q == FADE_MAX) state_d = (state_q == FADE_IN_T) ? TITLE_HOLD : GAME;
                    else                    fade_d  = fade_q + 4'd1;
                end
            end
            FADE_OUT_T, FADE_OUT_G: begin
                if (fade_step) begin
                    if (fade_q == 4'd0) state_d = (state_q == FADE_OUT_T) ? FADE_IN_G : FADE_IN_T;
                    else                fade_d  = fade_q - 4'd1;
                end
            end
            TITLE_HOLD: if (start_hit && (dwell_q >= MIN_CNT)) state_d = FADE_OUT_T;
            GAME:       if (game_over) state_d = GAME_OVER;
            GAME_OVER:  if (start_hit || (tick && (dwell_q == OVER_LAST))) state_d = FADE_OUT_G;
            default: begin
                state_d = FADE_IN_T;
                fade_d  = 4'd0;
            end
        endcase

        // frames spent in the current scene, restarted on every scene change
        dwell_d = dwell_q;
        if (state_d != state_q)          dwell_d = '0;
        else if (tick && dwell_q != '1) dwell_d = dwell_q + 16'd1;

        title_sel_d   = (state_d == FADE_IN_T) || (state_d == TITLE_HOLD) || (state_d == FADE_OUT_T);
        game_active_d = (state_d == GAME);
        game_start_d  = (state_d == FADE_IN_G) && (state_q != FADE_IN_G);
`ifdef TITLE_BLINK_EN
        if (state_d != TITLE_HOLD)      prompt_vis_d = 1'b0;
        else if (state_q != TITLE_HOLD) prompt_vis_d = 1'b1;
        else                            prompt_vis_d = prompt_vis_q ^ (blink_tick & blink_step);
`else
        prompt_vis_d  = (state_d == TITLE_HOLD);
`endif
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FADE_IN_T;
            fade_q        <= 4'd0;
            dwell_q       <= '0;
            title_sel_q   <= 1'b1;
            game_start_q  <= 1'b0;
            game_active_q <= 1'b0;
            prompt_vis_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fade_q        <= fade_d;
            dwell_q       <= dwell_d;
            title_sel_q   <= title_sel_d;
            game_start_q  <= game_start_d;
            game_active_q <= game_active_d;
            prompt_vis_q  <= prompt_vis_d;
        end
    end

    assign scene       = state_q;
    assign fade_level  = fade_q;
    assign title_sel   = title_sel_q;
    assign game_start  = game_start_q;
    assign game_active = game_active_q;
    assign prompt_vis  = prompt_vis_q;

endmodule

// File: tb/tb_title_scene_ctrl.sv
// Directed bench for title_scene_ctrl with FADE_STEP_FRAMES=2, MIN=60, OVER=180.
module tb_title_scene_ctrl;

    logic       vga_clk   = 1'b0;
    logic       reset_n   = 1'b0;
    logic       vs        = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] keycode   = 8'h00;
    logic       game_over = 1'b0;
    logic [2:0] scene;
    logic       title_sel;
    logic [3:0] fade_level;
    logic       game_start;
    logic       game_active;
    logic       prompt_vis;

    int n_total  = 0;
    int n_bad    = 0;
    int hold_cnt = 0;

    localparam logic [7:0] K_START = 8'h28;
    localparam logic [7:0] K_OTHER = 8'h04;

    title_scene_ctrl #(
        .FADE_STEP_FRAMES (2),
        .TITLE_MIN_FRAMES (60),
        .OVER_FRAMES      (180),
        .START_KEY        (K_START)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .vs          (vs),
        .key_valid   (key_valid),
        .keycode     (keycode),
        .game_over   (game_over),
        .scene       (scene),
        .title_sel   (title_sel),
        .fade_level  (fade_level),
        .game_start  (game_start),
        .game_active (game_active),
        .prompt_vis  (prompt_vis)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one vsync pulse; returns 1 time unit after the tick edge
    task automatic frame();
        @(posedge vga_clk); #1 vs = 1'b0;
        @(posedge vga_clk); #1 vs = 1'b1;
    endtask

    task automatic key(input logic [7:0] code, input bit with_tick);
        @(posedge vga_clk); #1;
        key_valid = 1'b1;
        keycode   = code;
        if (with_tick) vs = 1'b0;
        @(posedge vga_clk); #1;
        key_valid = 1'b0;
        vs        = 1'b1;
    endtask

    task automatic go();
        @(posedge vga_clk); #1 game_over = 1'b1;
        @(posedge vga_clk); #1 game_over = 1'b0;
    endtask

    function automatic logic exp_prompt();
`ifdef TITLE_BLINK_EN
        return ((hold_cnt / 32) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic run_fade(input bit up, input logic [2:0] cur, input logic [2:0] nxt, input string tag);
        for (int j = 1; j <= 32; j++) begin
            frame();
            if (j < 32) begin
                chk({tag, " scene"}, 32'(scene), 32'(cur));
                chk({tag, " level"}, 32'(fade_level), up ? j / 2 : 15 - j / 2);
            end else begin
                chk({tag, " end scene"}, 32'(scene), 32'(nxt));
                chk({tag, " end level"}, 32'(fade_level), up ? 15 : 0);
            end
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            frame();
            hold_cnt++;
            chk("hold scene", 32'(scene), 1);
            chk("hold prompt", 32'(prompt_vis), 32'(exp_prompt()));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge vga_clk);
        #1;
        chk("rst scene", 32'(scene), 0);
        chk("rst fade", 32'(fade_level), 0);
        chk("rst title_sel", 32'(title_sel), 1);
        chk("rst active", 32'(game_active), 0);
        chk("rst start", 32'(game_start), 0);
        chk("rst prompt", 32'(prompt_vis), 0);
        reset_n = 1'b1;

        // round 1: full flow with GAME_OVER timeout
        run_fade(1'b1, 3'd0, 3'd1, "fade_in_t");
        chk("hold title_sel", 32'(title_sel), 1);
        chk("hold entry prompt", 32'(prompt_vis), 1);
        hold_cnt = 0;
        hold(10);
        key(K_START, 1'b0);
        chk("early key", 32'(scene), 1);
        hold(49);
        key(K_START, 1'b0);
        chk("key at 59", 32'(scene), 1);
        hold(1);
        key(K_OTHER, 1'b0);
        chk("other key", 32'(scene), 1);
        key(K_START, 1'b0);
        chk("start accepted", 32'(scene), 2);
        chk("fade_out_t level", 32'(fade_level), 15);
        chk("fade_out_t prompt", 32'(prompt_vis), 0);
        chk("fade_out_t title_sel", 32'(title_sel), 1);

        run_fade(1'b0, 3'd2, 3'd3, "fade_out_t");
        chk("game_start high", 32'(game_start), 1);
        chk("fade_in_g title_sel", 32'(title_sel), 0);
        chk("fade_in_g active", 32'(game_active), 0);
        @(posedge vga_clk); #1;
        chk("game_start one cycle", 32'(game_start), 0);

        run_fade(1'b1, 3'd3, 3'd4, "fade_in_g");
        chk("game active", 32'(game_active), 1);
        chk("game title_sel", 32'(title_sel), 0);
        key(K_START, 1'b0);
        chk("start in game", 32'(scene), 4);
        go();
        chk("game_over scene", 32'(scene), 5);
        chk("game_over active", 32'(game_active), 0);
        chk("game_over level", 32'(fade_level), 15);
        go();
        chk("go in over", 32'(scene), 5);
        key(K_OTHER, 1'b0);
        chk("other in over", 32'(scene), 5);
        for (int i = 0; i < 179; i++) frame();
        chk("over 179", 32'(scene), 5);
        frame();
        chk("over 180", 32'(scene), 6);
        chk("over 180 level", 32'(fade_level), 15);
        run_fade(1'b0, 3'd6, 3'd0, "fade_out_g");
        chk("back to title", 32'(title_sel), 1);

        // round 2: key and tick together, then reset mid FADE_IN_G
        run_fade(1'b1, 3'd0, 3'd1, "fade_in_t2");
        hold_cnt = 0;
        hold(60);
        key(K_START, 1'b1);
        chk("key+tick scene", 32'(scene), 2);
        chk("key+tick level", 32'(fade_level), 15);
        frame();
        chk("cnt cleared t1", 32'(fade_level), 15);
        frame();
        chk("cnt cleared t2", 32'(fade_level), 14);
        for (int j = 3; j <= 32; j++) frame();
        chk("round2 fade_in_g", 32'(scene), 3);
        for (int i = 0; i < 5; i++) frame();
        chk("mid fade_in_g level", 32'(fade_level), 2);
        @(posedge vga_clk);
        #3 reset_n = 1'b0;
        #1;
        chk("async rst scene", 32'(scene), 0);
        chk("async rst fade", 32'(fade_level), 0);
        chk("async rst title_sel", 32'(title_sel), 1);
        repeat (3) @(posedge vga_clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge vga_clk); #1;
            chk("release start", 32'(game_start), 0);
            chk("release scene", 32'(scene), 0);
        end

        // round 3: START_KEY skips GAME_OVER
        run_fade(1'b1, 3'd0, 3'd1, "fade_in_t3");
        hold_cnt = 0;
        hold(60);
        key(K_START, 1'b0);
        chk("round3 start", 32'(scene), 2);
        run_fade(1'b0, 3'd2, 3'd3, "fade_out_t3");
        run_fade(1'b1, 3'd3, 3'd4, "fade_in_g3");
        go();
        chk("round3 over", 32'(scene), 5);
        for (int i = 0; i < 20; i++) frame();
        chk("over tick20", 32'(scene), 5);
        key(K_START, 1'b0);
        chk("skip over", 32'(scene), 6);
        chk("skip over level", 32'(fade_level), 15);
        frame();
        frame();
        chk("skip fade step", 32'(fade_level), 14);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
